// File: rtl/aux_seq_pkg.sv
// Shared types and register-map constants for the auxiliary count sequencer.
package aux_seq_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam logic [2:0] AddrCtrl   = 3'd0;
  localparam logic [2:0] AddrStatus = 3'd1;
  localparam logic [2:0] AddrValue  = 3'd2;
  localparam logic [2:0] AddrDwell  = 3'd3;
  localparam logic [2:0] AddrIdle   = 3'd4;
  localparam logic [2:0] AddrRepeat = 3'd5;

  localparam int unsigned CtrlStart    = 0;
  localparam int unsigned CtrlAbort    = 1;
  localparam int unsigned CtrlClear    = 2;
  localparam int unsigned CtrlClrFlags = 3;
  localparam int unsigned CtrlIrqEn    = 4;

  localparam int unsigned StatBusy   = 0;
  localparam int unsigned StatDone   = 1;
  localparam int unsigned StatOvf    = 2;
  localparam int unsigned StatIrqEn  = 4;
  localparam int unsigned StatCntLsb = 8;
  localparam int unsigned StatIdxLsb = 16;

  // Dwell field sized for the widest supported DWELL_W; narrower builds zero-extend.
  localparam int unsigned MaxDwellW = 32;

  typedef struct packed {
    logic [31:0]          value;
    logic [MaxDwellW-1:0] dwell;
  } step_t;

endpackage

// File: rtl/aux_seq_table.sv
// DEPTH-entry step register file: append at count, clear, asynchronous read.
module aux_seq_table
  import aux_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DWELL_W = 16,
  localparam int unsigned IdxW   = $clog2(DEPTH),
  localparam int unsigned CntW   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               append,
  input  logic [31:0]        append_value,
  input  logic [DWELL_W-1:0] append_dwell,
  input  logic               clear,
  input  logic [IdxW-1:0]    rd_idx,
  output step_t              rd_step,
  output logic [CntW-1:0]    count,
  output logic               full
);

  logic [31:0]        value_mem [DEPTH];
  logic [DWELL_W-1:0] dwell_mem [DEPTH];
  logic [CntW-1:0]    count_q;

  assign full  = (count_q == CntW'(DEPTH));
  assign count = count_q;

  // Storage is deliberately left unreset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (append && !full) begin
      value_mem[count_q[IdxW-1:0]] <= append_value;
      dwell_mem[count_q[IdxW-1:0]] <= append_dwell;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (append && !full) begin
      count_q <= count_q + CntW'(1);
    end
  end

  always_comb begin
    rd_step       = '0;
    rd_step.value = value_mem[rd_idx];
    rd_step.dwell = MaxDwellW'(dwell_mem[rd_idx]);
  end

endmodule

// File: rtl/aux_cnt_sequencer.sv
// Avalon-MM programmable sequencer stepping out_port through (value, dwell) entries.
// Optional level interrupt enabled by defining AUX_SEQ_IRQ_EN.
module aux_cnt_sequencer
  import aux_seq_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DWELL_W    = 16,
  parameter logic [31:0] IDLE_RESET = 32'd119
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        ext_trigger,
  output logic [31:0] out_port,
  output logic        busy,
  output logic        done
`ifdef AUX_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d, rd_idx;
  logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_load;
  logic [15:0]        passes_q, passes_d, repeat_q, repeat_eff;
  logic [31:0]        out_q, out_d, idle_q, idle_d, staging_q;
  logic               done_q, done_d, done_sticky_q, ovf_q;
  logic               bus_wr, ctrl_wr, start, abort, append, clear, at_last, running;
  step_t              rd_step;
  logic [CntW-1:0]    count;
  logic               full;

  assign bus_wr     = chipselect & ~write_n;
  assign ctrl_wr    = bus_wr && (address == AddrCtrl);
  assign abort      = ctrl_wr & writedata[CtrlAbort];
  assign start      = (ctrl_wr & writedata[CtrlStart]) | ext_trigger;
  assign running    = (state_q == StRun);
  assign append     = bus_wr && (address == AddrDwell) && !running && !full;
  assign clear      = ctrl_wr & writedata[CtrlClear] & ~running;
  assign at_last    = (CntW'(idx_q) == count - CntW'(1));
  assign repeat_eff = (repeat_q == 16'd0) ? 16'd1 : repeat_q;
  assign dwell_load = (rd_step.dwell == '0) ? DWELL_W'(1) : rd_step.dwell[DWELL_W-1:0];

  // The single read port always looks at the step that would be entered next.
  assign rd_idx = (running && !at_last) ? idx_q + 1'b1 : '0;

  aux_seq_table #(
    .DEPTH   (DEPTH),
    .DWELL_W (DWELL_W)
  ) u_table (
    .clk          (clk),
    .reset_n      (reset_n),
    .append       (append),
    .append_value (staging_q),
    .append_dwell (writedata[DWELL_W-1:0]),
    .clear        (clear),
    .rd_idx       (rd_idx),
    .rd_step      (rd_step),
    .count        (count),
    .full         (full)
  );

  always_comb begin
    idle_d = idle_q;
    if (bus_wr && (address == AddrIdle)) idle_d = writedata;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dwell_d  = dwell_q;
    passes_d = passes_q;
    out_d    = out_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        out_d = idle_d;
        if (start && !abort && (count != '0)) begin
          state_d  = StRun;
          idx_d    = '0;
          dwell_d  = dwell_load;
          passes_d = repeat_eff;
          out_d    = rd_step.value;
        end
      end
      StRun: begin
        if (abort || (dwell_q <= DWELL_W'(1) && at_last && passes_q <= 16'd1)) begin
          state_d = StIdle;
          idx_d   = '0;
          dwell_d = '0;
          out_d   = idle_d;
          done_d  = 1'b1;
        end else if (dwell_q > DWELL_W'(1)) begin
          dwell_d = dwell_q - DWELL_W'(1);
        end else begin
          if (at_last) passes_d = passes_q - 16'd1;
          idx_d   = rd_idx;
          dwell_d = dwell_load;
          out_d   = rd_step.value;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      dwell_q  <= '0;
      passes_q <= '0;
      out_q    <= IDLE_RESET;
      idle_q   <= IDLE_RESET;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dwell_q  <= dwell_d;
      passes_q <= passes_d;
      out_q    <= out_d;
      idle_q   <= idle_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      staging_q     <= '0;
      repeat_q      <= 16'd1;
      done_sticky_q <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      if (bus_wr && (address == AddrValue))  staging_q <= writedata;
      if (bus_wr && (address == AddrRepeat)) repeat_q  <= writedata[15:0];
      if (done_d) begin
        done_sticky_q <= 1'b1;
      end else if (ctrl_wr && writedata[CtrlClrFlags]) begin
        done_sticky_q <= 1'b0;
      end
      if (bus_wr && (address == AddrDwell) && !running && full) begin
        ovf_q <= 1'b1;
      end else if (ctrl_wr && writedata[CtrlClrFlags]) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef AUX_SEQ_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
    end else if (ctrl_wr) begin
      irq_en_q <= writedata[CtrlIrqEn];
    end
  end

  assign irq = done_sticky_q & irq_en_q;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      AddrStatus: begin
        readdata[StatBusy]          = running;
        readdata[StatDone]          = done_sticky_q;
        readdata[StatOvf]           = ovf_q;
`ifdef AUX_SEQ_IRQ_EN
        readdata[StatIrqEn]         = irq_en_q;
`endif
        readdata[StatCntLsb +: 8]   = 8'(count);
        readdata[StatIdxLsb +: 8]   = 8'(idx_q);
      end
      AddrValue:  readdata = staging_q;
      AddrDwell:  readdata = 32'(dwell_q);
      AddrIdle:   readdata = idle_q;
      AddrRepeat: readdata = 32'(repeat_q);
      default:    readdata = '0;
    endcase
  end

  assign out_port = out_q;
  assign busy     = running;
  assign done     = done_q;

endmodule

// File: tb/tb_aux_cnt_sequencer.sv
// Scoreboard bench: stimulus pushes the expected out_port trace, a negedge monitor checks it.
module tb_aux_cnt_sequencer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        ext_trigger = 1'b0;
  logic [31:0] out_port;
  logic        busy;
  logic        done;
`ifdef AUX_SEQ_IRQ_EN
  logic        irq;
`endif

  aux_cnt_sequencer #(
    .DEPTH      (DEPTH),
    .DWELL_W    (16),
    .IDLE_RESET (32'd119)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .ext_trigger (ext_trigger),
    .out_port    (out_port),
    .busy        (busy),
    .done        (done)
`ifdef AUX_SEQ_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [31:0] m_val[$];
  int          m_dw[$];
  logic [31:0] m_idle = 32'd119;
  int          m_rep = 1;
  bit          m_dsticky = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_irqen = 1'b0;

  logic [31:0] exp_q[$];
  int          pending_done = 0;
  bit          mon_en = 1'b0;
  logic [31:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en && reset_n) begin
      if (busy) begin
        if (exp_q.size() == 0) begin
          check("busy_extra", {31'd0, busy}, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("run_out", out_port, mon_exp);
        end
      end else if (done) begin
        if (pending_done == 0) begin
          check("done_spurious", {31'd0, done}, 32'd0);
        end else begin
          pending_done--;
          check("done_tail_len", exp_q.size(), 32'd0);
          check("done_out", out_port, m_idle);
        end
      end else begin
        check("idle_out", out_port, m_idle);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_raw(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_raw(a, d);
    case (a)
      3'd0: begin
        m_irqen = d[4];
        if (d[3]) begin m_dsticky = 1'b0; m_ovf = 1'b0; end
        if (d[2]) begin m_val.delete(); m_dw.delete(); end
      end
      3'd4: m_idle = d;
      3'd5: m_rep = int'(d[15:0]);
      default: ;
    endcase
  endtask

  task automatic add_step(input logic [31:0] v, input int d);
    wr(3'd2, v);
    wr(3'd3, 32'(d));
    if (m_val.size() < DEPTH) begin
      m_val.push_back(v);
      m_dw.push_back(d);
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic check_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[1] = m_dsticky;
    s[2] = m_ovf;
`ifdef AUX_SEQ_IRQ_EN
    s[4] = m_irqen;
`endif
    s[15:8] = 8'(m_val.size());
    return s;
  endfunction

  function automatic int seq_len();
    int passes = (m_rep == 0) ? 1 : m_rep;
    int n = 0;
    foreach (m_dw[i]) n += (m_dw[i] == 0) ? 1 : m_dw[i];
    return n * passes;
  endfunction

  // abort_after > 0: abort after that many active cycles have been presented.
  task automatic start_run(input int abort_after, input bit use_trig);
    int passes = (m_rep == 0) ? 1 : m_rep;
    int n = 0;
    if (m_val.size() > 0) begin
      for (int p = 0; p < passes; p++)
        for (int i = 0; i < m_val.size(); i++)
          for (int c = 0; c < ((m_dw[i] == 0) ? 1 : m_dw[i]); c++) begin
            if (abort_after <= 0 || n < abort_after) exp_q.push_back(m_val[i]);
            n++;
          end
      pending_done++;
      m_dsticky = 1'b1;
    end
    if (use_trig) begin
      ext_trigger = 1'b1;
      tick(1);
      ext_trigger = 1'b0;
    end else begin
      wr(3'd0, 32'h1 | (32'(m_irqen) << 4));
    end
    if (abort_after > 0) begin
      tick(abort_after - 1);
      wr(3'd0, 32'h2 | (32'(m_irqen) << 4));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pending_done != 0 || busy) && n < 500) begin
      tick(1);
      n++;
    end
    check("pending_done", pending_done, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    pending_done = 0;
    m_val.delete(); m_dw.delete();
    m_idle = 32'd119; m_rep = 1;
    m_dsticky = 1'b0; m_ovf = 1'b0; m_irqen = 1'b0;
  endtask

  initial begin
    int n, len, ab;
    tick(2);
    check("rst_out", out_port, 32'd119);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
`ifdef AUX_SEQ_IRQ_EN
    check("rst_irq", {31'd0, irq}, 32'd0);
`endif
    check_reg("rst_ctrl_rd", 3'd0, 32'd0);
    check_reg("rst_status", 3'd1, 32'd0);
    reset_n = 1'b1;
    tick(1);
    mon_en = 1'b1;

    wr(3'd4, 32'd5);
    check("idle_write_out", out_port, 32'd5);
    check_reg("idle_rd", 3'd4, 32'd5);
    check_reg("repeat_rd", 3'd5, 32'd1);
    check_reg("rsvd_rd", 3'd6, 32'd0);

    add_step(32'd10, 2); add_step(32'd20, 1); add_step(32'd30, 3);
    check_reg("value_rd", 3'd2, 32'd30);
    check_reg("status_cnt3", 3'd1, exp_status());
    start_run(0, 1'b0);
    wait_idle();
    check_reg("status_after_run", 3'd1, exp_status());

    wr(3'd5, 32'd2);
    start_run(0, 1'b0);
    wait_idle();

    // Abort during the 20 step, then restart from ext_trigger
    wr(3'd5, 32'd1);
    start_run(3, 1'b0);
    wait_idle();
    check_reg("status_after_abort", 3'd1, exp_status());
    start_run(0, 1'b1);
    wait_idle();

    // Start+abort in one CTRL write, and ext_trigger with abort: no run, no done
    wr(3'd0, 32'h3);
    tick(2);
    check("start_abort_busy", {31'd0, busy}, 32'd0);
    ext_trigger = 1'b1;
    wr(3'd0, 32'h2);
    ext_trigger = 1'b0;
    tick(2);
    check("trig_abort_busy", {31'd0, busy}, 32'd0);

    // Busy-time writes: start ignored, table writes dropped, IDLE deferred
    wr(3'd5, 32'd2);
    start_run(0, 1'b0);
    tick(1);
    wr_raw(3'd0, 32'h1);
    wr_raw(3'd3, 32'd7);
    wr_raw(3'd0, 32'h4);
    wr(3'd4, 32'd77);
    wait_idle();
    check_reg("status_busy_writes", 3'd1, exp_status());

    // Zero dwell holds one cycle
    wr(3'd0, 32'h4);
    wr(3'd5, 32'd1);
    add_step(32'd42, 0); add_step(32'd43, 0); add_step(32'd44, 2);
    start_run(0, 1'b0);
    wait_idle();
    wr(3'd0, 32'h8);
    check_reg("status_flags_cleared", 3'd1, exp_status());

    // Overflow then empty-table start
    wr(3'd0, 32'h4);
    for (int i = 0; i < DEPTH + 1; i++) add_step($urandom, int'($urandom_range(0, 3)));
    check_reg("status_overflow", 3'd1, exp_status());
    wr(3'd0, 32'h4);
    start_run(0, 1'b0);
    tick(3);
    check("empty_start_busy", {31'd0, busy}, 32'd0);
    check_reg("status_empty", 3'd1, exp_status());

    // Randomised tables, repeats, idle values, aborts
    for (int it = 0; it < 20; it++) begin
      wr(3'd0, 32'h4);
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) add_step($urandom, int'($urandom_range(0, 3)));
      wr(3'd5, 32'($urandom_range(0, 3)));
      wr(3'd4, $urandom);
      len = seq_len();
      ab = (len > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, len - 1)) : 0;
      start_run(ab, 1'($urandom_range(0, 1)));
      wait_idle();
      check_reg("status_rand", 3'd1, exp_status());
    end

    // Asynchronous reset mid-sequence
    wr(3'd0, 32'h4);
    add_step(32'd1234, 9);
    start_run(0, 1'b0);
    tick(2);
    reset_n = 1'b0;
    #1;
    check("async_rst_out", out_port, 32'd119);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    model_reset();
    check_reg("async_rst_status", 3'd1, exp_status());
    tick(1);
    reset_n = 1'b1;
    tick(1);

`ifdef AUX_SEQ_IRQ_EN
    add_step(32'd55, 2);
    wr(3'd0, 32'h10);
    start_run(0, 1'b0);
    wait_idle();
    check("irq_set", {31'd0, irq}, 32'd1);
    wr(3'd0, 32'h18);
    check("irq_clr", {31'd0, irq}, 32'd0);
    check_reg("status_irq", 3'd1, exp_status());
`endif

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
